// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver datapath: direction codes, coordinate
// width, run-length limit and the path_encoder state encoding.
package maze_pkg;

    localparam int COORD_W = 4;
    localparam int RUN_MAX = 15;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_POP_FIRST   = 4'd1;
    localparam logic [3:0] ST_LATCH_FIRST = 4'd2;
    localparam logic [3:0] ST_POP         = 4'd3;
    localparam logic [3:0] ST_DECODE      = 4'd4;
    localparam logic [3:0] ST_EMIT        = 4'd5;
    localparam logic [3:0] ST_FLUSH       = 4'd6;
    localparam logic [3:0] ST_DONE        = 4'd7;
    localparam logic [3:0] ST_ERR         = 4'd8;

    typedef enum logic [3:0] {
        IDLE        = ST_IDLE,
        POP_FIRST   = ST_POP_FIRST,
        LATCH_FIRST = ST_LATCH_FIRST,
        POP         = ST_POP,
        DECODE      = ST_DECODE,
        EMIT        = ST_EMIT,
        FLUSH       = ST_FLUSH,
        DONE        = ST_DONE,
        ERR         = ST_ERR
    } pe_state_t;

endpackage

// File: rtl/move_decoder.sv
// Combinational compass decoder: classifies the step from prev to cur and
// reports whether the two cells are 4-neighbours.
import maze_pkg::*;

module move_decoder (
    input  logic [2*COORD_W-1:0] prev,
    input  logic [2*COORD_W-1:0] cur,
    output logic [1:0]           dir,
    output logic                 adj
);

    logic signed [COORD_W:0] d_row;
    logic signed [COORD_W:0] d_col;

    // One extra bit keeps 0 -> 15 a distance of 15 rather than a wrap to -1.
    assign d_row = $signed({1'b0, cur[2*COORD_W-1:COORD_W]}) - $signed({1'b0, prev[2*COORD_W-1:COORD_W]});
    assign d_col = $signed({1'b0, cur[COORD_W-1:0]}) - $signed({1'b0, prev[COORD_W-1:0]});

    always_comb begin
        adj = 1'b0;
        dir = DIR_LEFT;
        if (d_row == 0 && (d_col == 1 || d_col == -1)) begin
            adj = 1'b1;
            dir = (d_col == 1) ? DIR_RIGHT : DIR_LEFT;
        end else if (d_col == 0 && (d_row == 1 || d_row == -1)) begin
            adj = 1'b1;
            dir = (d_row == 1) ? DIR_DOWN : DIR_UP;
        end
    end

endmodule

// File: rtl/path_encoder.sv
// Drains the solved-path queue, turns consecutive cells into compass moves and
// run-length encodes them into {dir,len} tokens on a valid/ready output.
import maze_pkg::*;

module path_encoder #(
    parameter int RUN_MAX = maze_pkg::RUN_MAX
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       q_empty,
    input  logic [7:0] q_data,
    output logic       q_pop,
    output logic       mv_valid,
    output logic [1:0] mv_dir,
    output logic [3:0] mv_len,
    input  logic       mv_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] steps
);

    localparam logic [3:0] RUN_MAX_L = 4'(RUN_MAX);

    pe_state_t  state;
    pe_state_t  next_state;
    logic [7:0] prev;
    logic [3:0] len;
    logic [1:0] cur_dir;
    logic [1:0] pend_dir;
    logic [1:0] dec_dir;
    logic       dec_adj;
    logic       extend;

    move_decoder u_dec (
        .prev (prev),
        .cur  (q_data),
        .dir  (dec_dir),
        .adj  (dec_adj)
    );

    assign extend = (len == 4'd0) || (dec_dir == cur_dir && len < RUN_MAX_L);

    always_ff @(posedge clk) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        q_pop      = 1'b0;
        mv_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = q_empty ? DONE : POP_FIRST;
            end
            POP_FIRST: begin
                q_pop      = 1'b1;
                next_state = LATCH_FIRST;
            end
            LATCH_FIRST: next_state = POP;
            POP: begin
                if (q_empty) begin
                    next_state = (len != 4'd0) ? FLUSH : DONE;
                end else begin
                    q_pop      = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (!dec_adj)    next_state = ERR;
                else if (extend) next_state = POP;
                else             next_state = EMIT;
            end
            EMIT: begin
                mv_valid = 1'b1;
                if (mv_ready) next_state = POP;
            end
            FLUSH: begin
                mv_valid = 1'b1;
                if (mv_ready) next_state = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            ERR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Run tracking and the registered output token; the token is loaded one
    // cycle before it is presented so mv_dir/mv_len never change under valid.
    always_ff @(posedge clk) begin
        if (!RST) begin
            prev     <= '0;
            len      <= '0;
            cur_dir  <= '0;
            pend_dir <= '0;
            mv_dir   <= '0;
            mv_len   <= '0;
            steps    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        steps <= '0;
                        len   <= '0;
                    end
                end
                LATCH_FIRST: begin
                    prev <= q_data;
                    len  <= '0;
                end
                POP: begin
                    if (q_empty && len != 4'd0) begin
                        mv_dir <= cur_dir;
                        mv_len <= len;
                    end
                end
                DECODE: begin
                    if (dec_adj) begin
                        prev <= q_data;
                        if (steps != 8'hFF) steps <= steps + 8'd1;
                        if (len == 4'd0) begin
                            cur_dir <= dec_dir;
                            len     <= 4'd1;
                        end else if (extend) begin
                            len <= len + 4'd1;
                        end else begin
                            mv_dir   <= cur_dir;
                            mv_len   <= len;
                            pend_dir <= dec_dir;
                        end
                    end
                end
                EMIT: begin
                    if (mv_ready) begin
                        cur_dir <= pend_dir;
                        len     <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/path_encoder.md
# path_encoder

Downstream stage of the rat-in-maze solver: drains the solved-path queue after the controller reaches its done state, converts consecutive `{row,col}` cells into compass moves, and run-length encodes them into `{dir,len}` tokens on a valid/ready output. It also counts total steps and flags any pair of consecutive cells that are not 4-neighbours, which indicates corrupt path data.

## Interface
- `RUN_MAX`, default 15: largest run length carried by one token; must fit in `len`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin draining; sampled only in IDLE.
- `q_empty` in 1: path queue empty.
- `q_data` in 8: `{row[3:0], col[3:0]}`; valid the cycle after `q_pop`.
- `q_pop` out 1: path queue pop strobe, one cycle per entry.
- `mv_valid` out 1: token valid.
- `mv_dir` out 2: 00 up (row−1), 01 right (col+1), 10 down (row+1), 11 left (col−1).
- `mv_len` out 4: run length, 1..RUN_MAX.
- `mv_ready` in 1: consumer accepts the token.
- `busy` out 1: high from the accepted `start` until DONE or ERR.
- `done` out 1: level, held high in DONE.
- `err` out 1: level, held high in ERR.
- `steps` out 8: total moves decoded; saturates at 255.

## Operation
- **FSM states:** IDLE, POP_FIRST, LATCH_FIRST, POP, DECODE, EMIT, FLUSH, DONE, ERR.
- **IDLE:**
  - `start` = 1 and `q_empty` = 1 → DONE, `steps` = 0.
  - `start` = 1 and `q_empty` = 0 → POP_FIRST.
  - `start` is ignored in every other state.
- **POP_FIRST / LATCH_FIRST:** POP_FIRST asserts `q_pop`. LATCH_FIRST registers `q_data` as `prev`, clears the run (`len` = 0) and goes to POP.
- **POP:**
  - `q_empty` = 1 → FLUSH if `len` > 0, else DONE.
  - `q_empty` = 0 → assert `q_pop` and go to DECODE.
- **DECODE:** compare `q_data` with `prev`.
  - Not adjacent (Manhattan distance ≠ 1, which includes equal cells) → ERR.
  - Otherwise, with direction `d`: `prev` ← `q_data`; `steps` += 1 (saturating).
  - `len` = 0 → `cur_dir` ← d, `len` ← 1, go to POP.
  - `d` == `cur_dir` and `len` < RUN_MAX → `len` += 1, go to POP.
  - Otherwise → load the output token `{cur_dir, len}`, stash `d` as the pending new run, go to EMIT.
- **EMIT:** `mv_valid` = 1 with the token held stable until `mv_ready` = 1. On that handshake: `cur_dir` ← pending dir, `len` ← 1, go to POP.
- **FLUSH:** presents the final run `{cur_dir, len}`. Handshake → DONE.
- **DONE / ERR:** outputs hold. A new `start` does not restart the block; only `RST` returns it to IDLE.
- **Arithmetic:**
  - Coordinates are unsigned 4-bit; differences are computed 5-bit signed, so no wrap is possible (0→15 is not adjacent).
  - `steps` is 8-bit. A 16×16 path has at most 255 steps, so saturation is defensive only.
- **Single-cell path** (exactly one entry): DONE, `steps` = 0, no tokens emitted.

## Timing
- **Reset:** `RST` = 0 at a clock edge forces IDLE; all outputs become 0, `steps` = 0, `len` = 0. Mid-operation reset abandons the run; any entry already popped is lost and not re-read.
- **Queue read latency:** 1 cycle. `q_pop` in cycle t → `q_data` is sampled in cycle t+1. `q_pop` is never high in two consecutive cycles.
- **Throughput:** without emission, one cell per 2 cycles (POP, DECODE). An emission adds ≥1 cycle (EMIT, plus any stall).
- **Output handshake:** `mv_valid` never drops without a handshake. `mv_dir`/`mv_len` are registered and stable while `mv_valid` is high. `mv_ready` is ignored while `mv_valid` = 0.
- **Latency from `start`:** first `q_pop` in the cycle after `start` is sampled. `done` rises in the cycle after the last handshake, or after POP sees `q_empty` with `len` = 0.
- **Error:** `err` rises the cycle after the offending DECODE. The pending run is discarded.

## Structure
- **Shared package `maze_pkg`:** direction codes (DIR_UP/RIGHT/DOWN/LEFT), coordinate width (4), RUN_MAX, and the `path_encoder` state encoding as localparams. The solver controller reuses the coordinate width.
- **Sub-module `move_decoder`:** combinational; takes `prev` and `cur` `{row,col}`, returns `dir[1:0]` and `adj`. It is instantiated once inside `path_encoder`.

## Test plan
- **Straight run:** queue (0,0),(0,1)…(0,5); `mv_ready` = 1 → one token {01,5}, `steps` = 5, then `done`.
- **RUN_MAX split:** queue (0,0),(1,0)…(15,0), 15 down steps, then (15,1) → tokens {10,15},{01,1}, `steps` = 16.
- **L-path with backpressure:** (2,2),(2,3),(2,4),(3,4); `mv_ready` held low 3 cycles at the first token → token {01,2} stays stable for 4 cycles, then {10,1}, `done`.
- **Non-adjacent / corner cases:**
  - (0,0),(0,1),(1,2) → `err` = 1, `steps` = 1, no token emitted.
  - Repeat with (5,5),(5,5) → `err`.
- **Degenerate queues:**
  - `start` with `q_empty` = 1 → `done` the next cycle, `steps` = 0, `q_pop` never asserted.
  - Single entry (7,7) → `done`, no tokens.
- **Mid-operation reset:** `RST` = 0 for 1 cycle during EMIT → next cycle IDLE, `mv_valid` = 0, `steps` = 0. A new `start` on the remaining queue decodes from the next entry.
